// File: rtl/comp_serial.sv
// Bit-serial unsigned magnitude comparator, MSB-first, one bit pair per clock.
// Latency: done pulses k cycles after the accept edge (k = equal leading pairs + 1, capped at WIDTH).
// Backpressure: none; start is only sampled in IDLE, is ignored while busy, and requests are never queued.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start, A, B         comparison request and operands, captured on the accept edge
//   busy, done          comparison in progress / one-cycle completion pulse
//   Amaior, igual,      word-level result (A > B, A == B, A < B), held until the
//   Amenor              next accept edge or reset
module comp_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             Amaior,
    output logic             igual,
    output logic             Amenor
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARA = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [IW-1:0]    r_idx;
    logic             r_done;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_sh_a_nxt;
    logic [WIDTH-1:0] w_sh_b_nxt;
    logic [IW-1:0]    w_idx_nxt;
    logic             w_done_nxt;
    logic             w_gt_nxt;
    logic             w_eq_nxt;
    logic             w_lt_nxt;

    // Bits under comparison are always the MSBs of the shift registers.
    logic             w_a;
    logic             w_b;

    assign w_a = r_sh_a[WIDTH-1];
    assign w_b = r_sh_b[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sh_a  <= w_sh_a_nxt;
            r_sh_b  <= w_sh_b_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
            r_gt    <= w_gt_nxt;
            r_eq    <= w_eq_nxt;
            r_lt    <= w_lt_nxt;
        end
    end

    always_comb begin
        // Default: hold everything, done is a single-cycle pulse.
        w_state_nxt = r_state;
        w_sh_a_nxt  = r_sh_a;
        w_sh_b_nxt  = r_sh_b;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_gt_nxt    = r_gt;
        w_eq_nxt    = r_eq;
        w_lt_nxt    = r_lt;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_sh_a_nxt  = A;
                    w_sh_b_nxt  = B;
                    w_idx_nxt   = IW'(WIDTH - 1);
                    w_gt_nxt    = 1'b0;
                    w_eq_nxt    = 1'b0;
                    w_lt_nxt    = 1'b0;
                    w_state_nxt = COMPARA;
                end
            end
            COMPARA: begin
                if (w_a && !w_b) begin
                    w_gt_nxt    = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (!w_a && w_b) begin
                    w_lt_nxt    = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_idx == '0) begin
                    // Last pair and every pair matched.
                    w_eq_nxt    = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_sh_a_nxt  = {r_sh_a[WIDTH-2:0], 1'b0};
                    w_sh_b_nxt  = {r_sh_b[WIDTH-2:0], 1'b0};
                    w_idx_nxt   = r_idx - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy   = (r_state == COMPARA);
    assign done   = r_done;
    assign Amaior = r_gt;
    assign igual  = r_eq;
    assign Amenor = r_lt;

endmodule

// File: tb/tb_comp_serial.sv
// Self-checking bench for comp_serial: directed vectors plus an exhaustive 4-bit sweep.
// Expected results and latencies are queued at issue time; a monitor checks them on done.
// Outputs are sampled on the falling edge, inputs driven right after the falling edge.
module tb_comp_serial;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             Amaior;
    logic             igual;
    logic             Amenor;

    comp_serial #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Amaior (Amaior),
        .igual  (igual),
        .Amenor (Amenor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [2:0] res;   // {gt, eq, lt}
        int         k;
        int         acc;   // cycle number of the accept edge
    } exp_t;

    exp_t q[$];

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Monitor: busy run length is the number of consecutive busy cycles before done.
    int bcnt = 0;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", {Amaior, igual, Amenor}, e.res);
                chk("latency", cyc - e.acc, e.k);
                chk("busy_len", bcnt, e.k);
            end
            bcnt = 0;
        end else if (busy === 1'b1) begin
            bcnt++;
        end else begin
            bcnt = 0;
        end
    end

    // Called just after a falling edge; the next rising edge is the accept edge.
    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] res, input int k, input bit track);
        A     = a;
        B     = b;
        start = 1'b1;
        if (track) q.push_back('{res: res, k: k, acc: cyc + 1});
    endtask

    // Returns at the falling edge on which done is seen, or flags a timeout.
    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    task automatic run(input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] res, input int k);
        @(negedge clk);
        issue(a, b, res, k, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_done();
    endtask

    function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                  output logic [2:0] res, output int k);
        res = (a > b) ? GT : (a < b) ? LT : EQ;
        k   = WIDTH;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (a[i] != b[i]) begin
                k = WIDTH - i;
                break;
            end
        end
    endfunction

    initial begin
        logic [2:0] mres;
        int         mk;

        // Reset with start held high: nothing may be accepted.
        rst   = 1'b1;
        start = 1'b1;
        A     = 4'b1010;
        B     = 4'b1000;
        repeat (2) begin
            @(negedge clk);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_result", {Amaior, igual, Amenor}, 3'b000);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        // Decision on the third bit, then results must hold.
        run(4'b1010, 4'b1000, GT, 3);
        repeat (2) @(negedge clk);
        chk("hold_result", {Amaior, igual, Amenor}, GT);
        chk("hold_done", done, 0);

        // First-bit decision.
        run(4'b0111, 4'b1000, LT, 1);

        // Full-length equality.
        run(4'b0110, 4'b0110, EQ, 4);
        run(4'b0000, 4'b0000, EQ, 4);

        // start held high for the whole comparison, dropped in the done cycle.
        @(negedge clk);
        issue(4'b1001, 4'b1011, LT, 3, 1'b1);
        wait_done();
        start = 1'b0;
        @(negedge clk);
        chk("held_start_idle", busy, 0);

        // Back-to-back: a new start in the done cycle is accepted.
        @(negedge clk);
        issue(4'b1100, 4'b0100, GT, 1, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        issue(4'b0001, 4'b0011, LT, 3, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_cleared", {Amaior, igual, Amenor}, 3'b000);
        chk("b2b_done_drop", done, 0);
        chk("b2b_busy", busy, 1);
        wait_done();

        // Operands changed after the accept edge.
        @(negedge clk);
        issue(4'b1100, 4'b1101, LT, 4, 1'b1);
        @(negedge clk);
        start = 1'b0;
        A     = 4'b1111;
        B     = 4'b0000;
        wait_done();

        // Reset on the second COMPARA cycle discards the comparison.
        @(negedge clk);
        issue(4'b1111, 4'b1110, GT, 4, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", {Amaior, igual, Amenor}, 3'b000);
        repeat (WIDTH + 2) @(negedge clk);
        chk("midrst_still_idle", {busy, done}, 2'b00);

        // Exhaustive sweep against the reference model.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                model(4'(a), 4'(b), mres, mk);
                run(4'(a), 4'(b), mres, mk);
            end
        end

        repeat (2) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/comp_serial.md
Name: comp_serial

Overview:
- Bit-serial magnitude comparator for two WIDTH-bit unsigned words.
- It is the consumer stage built around the single-bit comparison (Amaior / igual / Amenor per bit pair).
- It walks the operands MSB-first, one bit pair per clock, stops at the first differing bit, and reports the word-level result with a start/busy/done handshake.
- It sits between the operand registers of the datapath and the control logic that needs a word-level comparison.

Parameters:
- WIDTH, 4, operand width in bits; legal range is 2 or more.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request a comparison; sampled only in IDLE.
- A  input  WIDTH  operand A, unsigned; captured on the accept edge.
- B  input  WIDTH  operand B, unsigned; captured on the accept edge.
- busy  output  1  high while a comparison is in progress (state COMPARA).
- done  output  1  one-cycle pulse; result outputs are valid from this cycle on.
- Amaior  output  1  result: A > B.
- igual  output  1  result: A == B.
- Amenor  output  1  result: A < B.

Behaviour:
- Reset: when rst is high at a clock edge, the following take effect after that edge.
  - State goes to IDLE.
  - busy, done, Amaior, igual and Amenor are all 0.
  - Internal shift registers and the bit index are 0.
  - rst has priority over every other input, including mid-comparison; any in-flight comparison is discarded with no done pulse.
- All outputs are registered. There is no combinational path from inputs to outputs.
- IDLE:
  - busy = 0.
  - If start = 1 at an edge, that edge is the accept edge:
    - load shA <= A and shB <= B;
    - set the index to WIDTH-1;
    - clear Amaior, igual and Amenor to 0;
    - go to COMPARA.
  - If start = 0, stay in IDLE and hold the result outputs.
- COMPARA (busy = 1), one bit pair per edge:
  - The current bits are a = shA[WIDTH-1] and b = shB[WIDTH-1], i.e. the MSB of each shift register.
  - a=1, b=0: set Amaior=1 and done=1, go to IDLE (early termination).
  - a=0, b=1: set Amenor=1 and done=1, go to IDLE (early termination).
  - a==b and index==0: set igual=1 and done=1, go to IDLE.
  - a==b and index>0: shift both registers left by 1 (zero fill), decrement the index, stay in COMPARA.
  - start is ignored while in COMPARA; there is no queueing.
- done rules:
  - done is high for exactly one cycle, the cycle after the decision edge.
  - It is cleared on the following edge.
- Result outputs:
  - Exactly one of Amaior, igual, Amenor is 1 after a completed comparison.
  - They hold that value until the next accept edge or reset.
- Latency:
  - k = (number of equal leading bit pairs) + 1, capped at WIDTH.
  - done is high k cycles after the accept edge; the minimum is 1 and the maximum is WIDTH.
  - busy is high for exactly k cycles.
- Back-to-back operation:
  - The FSM is already in IDLE during the done cycle.
  - A start sampled high in that cycle is accepted.
  - That accept edge clears the results and drops done.
- Operand changes:
  - A and B may change freely after the accept edge; they do not affect an in-flight comparison.
- Encoding:
  - Two-state FSM (IDLE, COMPARA).
  - The index needs $clog2(WIDTH) bits.
  - There is no illegal-state recovery beyond reset.

Test Plan:
1. Reset check: hold rst=1 for 2 cycles with start=1 -> after the reset edges all outputs are 0, busy=0 and done never pulses.
2. Early decision, A greater: A=4'b1010, B=4'b1000, start pulsed 1 cycle -> busy high 3 cycles, done pulses 3 cycles after the accept edge, Amaior=1, igual=0, Amenor=0, and the results hold afterwards.
3. First-bit decision, A smaller: A=4'b0111, B=4'b1000 -> done 1 cycle after the accept edge, Amenor=1, busy high only 1 cycle.
4. Full-length equality: A=B=4'b0110 -> done after 4 cycles with igual=1; then A=B=4'b0000 -> igual=1 after 4 cycles.
5. Handshake corners:
   - start held high during COMPARA -> ignored;
   - start high in the done cycle with A=4'b0001, B=4'b0011 -> accepted, results cleared at the accept edge, Amenor=1 three cycles later;
   - operands changed mid-comparison -> the result is unchanged.
6. Reset mid-operation: start A=4'b1111, B=4'b1110, assert rst on the 2nd COMPARA cycle -> IDLE, all outputs 0, no done pulse; then run an exhaustive 256-pair sweep against a reference model -> results and latency k match for every pair.
